// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the 2-bit phase encoding used by the
// H and V phase trackers.
package vga_timing_pkg;

    localparam int unsigned CNT_W    = 11;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef enum logic [1:0] {
        PhActive = 2'd0,
        PhFront  = 2'd1,
        PhSync   = 2'd2,
        PhBack   = 2'd3
    } phase_e;

endpackage

// File: rtl/vga_phase_fsm.sv
// Tracks one axis through ACTIVE -> FRONT -> SYNC -> BACK. The registered phase
// always belongs to the count captured on the same edge.
module vga_phase_fsm
    import vga_timing_pkg::*;
#(
    parameter int unsigned CNT_W = 11,
    parameter int unsigned ACT   = 640,
    parameter int unsigned FP    = 16,
    parameter int unsigned SYNC  = 96,
    parameter int unsigned BP    = 48
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             adv,
    input  logic             eval,
    input  logic             resync,
    input  logic [CNT_W-1:0] cnt,
    output logic [1:0]       phase,
    output logic             in_range
);

    localparam logic [CNT_W-1:0] FrontAt = CNT_W'(ACT);
    localparam logic [CNT_W-1:0] SyncAt  = CNT_W'(ACT + FP);
    localparam logic [CNT_W-1:0] BackAt  = CNT_W'(ACT + FP + SYNC);
    localparam logic [CNT_W-1:0] Total   = CNT_W'(ACT + FP + SYNC + BP);

    phase_e state_q, state_d, decoded;

    // Phase implied by the count alone; used to recover after a bad sequence.
    always_comb begin
        decoded = PhBack;
        if (cnt < FrontAt) begin
            decoded = PhActive;
        end else if (cnt < SyncAt) begin
            decoded = PhFront;
        end else if (cnt < BackAt) begin
            decoded = PhSync;
        end
    end

    always_comb begin
        state_d = state_q;
        if (resync) begin
            state_d = decoded;
        end else if (eval) begin
            case (state_q)
                PhActive: if (cnt == FrontAt) state_d = PhFront;
                PhFront:  if (cnt == SyncAt)  state_d = PhSync;
                PhSync:   if (cnt == BackAt)  state_d = PhBack;
                PhBack:   if (cnt == '0)      state_d = PhActive;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= PhActive;
        end else if (adv) begin
            state_q <= state_d;
        end
    end

    assign phase    = state_q;
    assign in_range = cnt < Total;

endmodule

// File: rtl/vga_sync_timing.sv
// Two-stage VGA sync decoder: stage 1 captures counts and phases, stage 2 drives
// sync, blanking, pixel coordinates, strobes and the frame counter.
module vga_sync_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned CNT_W    = vga_timing_pkg::CNT_W,
    parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
    parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             pix_en,
    input  logic [CNT_W-1:0] h_cnt,
    input  logic [CNT_W-1:0] v_cnt,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [9:0]       pixel_x,
    output logic [9:0]       pixel_y,
    output logic             line_start,
    output logic             frame_start,
    output logic [7:0]       frame_cnt,
    output logic             cnt_err
);

    localparam int unsigned      HTot  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned      VTot  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] HLast = CNT_W'(HTot - 1);
    localparam logic [CNT_W-1:0] VLast = CNT_W'(VTot - 1);

    logic             s1_valid_q, s1_bad_q;
    logic [CNT_W-1:0] s1_h_q, s1_v_q;
    logic [1:0]       h_phase, v_phase;
    logic             h_in_range, v_in_range;
    logic             h_zero, h_seq_ok, v_step_ok, v_seq_ok, bad, resync;

    logic       hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q, cnt_err_q;
    logic [9:0] pixel_x_q, pixel_y_q;
    logic [7:0] frame_cnt_q;
    logic       hsync_d, vsync_d, video_on_d, line_start_d, frame_start_d;
    logic [9:0] pixel_x_d, pixel_y_d;

    // Sequence check against the previously captured counts.
    always_comb begin
        h_zero    = h_cnt == '0;
        h_seq_ok  = (s1_h_q == HLast) ? h_zero : (h_cnt == s1_h_q + 1'b1);
        v_step_ok = (s1_v_q == VLast) ? (v_cnt == '0) : (v_cnt == s1_v_q + 1'b1);
        v_seq_ok  = (v_cnt == s1_v_q) || (h_zero && v_step_ok);
        bad       = !h_in_range || !v_in_range || (s1_valid_q && !(h_seq_ok && v_seq_ok));
        // Before the first capture the FSMs know nothing, so lock them to the counts.
        resync    = bad || !s1_valid_q;
    end

    vga_phase_fsm #(
        .CNT_W (CNT_W),
        .ACT   (H_ACTIVE),
        .FP    (H_FP),
        .SYNC  (H_SYNC),
        .BP    (H_BP)
    ) u_h_fsm (
        .Clk      (Clk),
        .reset    (reset),
        .adv      (pix_en),
        .eval     (1'b1),
        .resync   (resync),
        .cnt      (h_cnt),
        .phase    (h_phase),
        .in_range (h_in_range)
    );

    vga_phase_fsm #(
        .CNT_W (CNT_W),
        .ACT   (V_ACTIVE),
        .FP    (V_FP),
        .SYNC  (V_SYNC),
        .BP    (V_BP)
    ) u_v_fsm (
        .Clk      (Clk),
        .reset    (reset),
        .adv      (pix_en),
        .eval     (h_zero),
        .resync   (resync),
        .cnt      (v_cnt),
        .phase    (v_phase),
        .in_range (v_in_range)
    );

    always_ff @(posedge Clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_bad_q   <= 1'b0;
            s1_h_q     <= '0;
            s1_v_q     <= '0;
        end else if (pix_en) begin
            s1_valid_q <= 1'b1;
            s1_bad_q   <= bad;
            s1_h_q     <= h_cnt;
            s1_v_q     <= v_cnt;
        end
    end

    always_comb begin
        hsync_d       = (h_phase == PhSync && !s1_bad_q) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = (v_phase == PhSync && !s1_bad_q) ? SYNC_POL : ~SYNC_POL;
        video_on_d    = h_phase == PhActive && v_phase == PhActive && !s1_bad_q;
        pixel_x_d     = video_on_d ? s1_h_q[9:0] : 10'd0;
        pixel_y_d     = video_on_d ? s1_v_q[9:0] : 10'd0;
        line_start_d  = !s1_bad_q && s1_h_q == '0;
        frame_start_d = line_start_d && s1_v_q == '0;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
            cnt_err_q     <= 1'b0;
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            if (pix_en && s1_valid_q) begin
                hsync_q       <= hsync_d;
                vsync_q       <= vsync_d;
                video_on_q    <= video_on_d;
                pixel_x_q     <= pixel_x_d;
                pixel_y_q     <= pixel_y_d;
                line_start_q  <= line_start_d;
                frame_start_q <= frame_start_d;
                cnt_err_q     <= cnt_err_q | s1_bad_q;
                if (frame_start_d) begin
                    frame_cnt_q <= frame_cnt_q + 8'd1;
                end
            end
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;
    assign cnt_err     = cnt_err_q;

endmodule

// File: tb/tb_vga_sync_timing.sv
// Scoreboard bench for vga_sync_timing: expected outputs are modelled from the
// counts as they are driven and compared two pix_en edges later.
module tb_vga_sync_timing;

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_en = 1'b0;
    logic [10:0] h_cnt = '0;
    logic [10:0] v_cnt = '0;
    logic        hsync, vsync, video_on, line_start, frame_start, cnt_err;
    logic [9:0]  pixel_x, pixel_y;
    logic [7:0]  frame_cnt;

    vga_sync_timing dut (
        .Clk         (Clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt),
        .cnt_err     (cnt_err)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       vid;
        logic [9:0] px;
        logic [9:0] py;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
        logic       err;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    logic       m_armed;
    int         m_prev_h, m_prev_v;
    logic [7:0] m_fc;
    logic       m_err;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic compare_out(input exp_t e, input logic idle);
        check_eq("hsync", 32'(hsync), 32'(e.hs));
        check_eq("vsync", 32'(vsync), 32'(e.vs));
        check_eq("video_on", 32'(video_on), 32'(e.vid));
        check_eq("pixel_x", 32'(pixel_x), 32'(e.px));
        check_eq("pixel_y", 32'(pixel_y), 32'(e.py));
        check_eq("line_start", 32'(line_start), idle ? 32'd0 : 32'(e.ls));
        check_eq("frame_start", 32'(frame_start), idle ? 32'd0 : 32'(e.fs));
        check_eq("frame_cnt", 32'(frame_cnt), 32'(e.fc));
        check_eq("cnt_err", 32'(cnt_err), 32'(e.err));
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        pix_en = 1'b0;
        @(posedge Clk);
        #1;
        check_eq("rst_hsync", 32'(hsync), 32'd1);
        check_eq("rst_vsync", 32'(vsync), 32'd1);
        check_eq("rst_video_on", 32'(video_on), 32'd0);
        check_eq("rst_pixel_x", 32'(pixel_x), 32'd0);
        check_eq("rst_pixel_y", 32'(pixel_y), 32'd0);
        check_eq("rst_line_start", 32'(line_start), 32'd0);
        check_eq("rst_frame_start", 32'(frame_start), 32'd0);
        check_eq("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check_eq("rst_cnt_err", 32'(cnt_err), 32'd0);
        reset    = 1'b0;
        q.delete();
        m_armed  = 1'b0;
        m_prev_h = 0;
        m_prev_v = 0;
        m_fc     = '0;
        m_err    = 1'b0;
    endtask

    // One pix_en pulse followed by one idle Clk.
    task automatic drive(input int h, input int v);
        exp_t e;
        logic range_bad, h_ok, v_ok, v_step, bad;
        range_bad = (h >= 800) || (v >= 525);
        h_ok      = (m_prev_h == 799) ? (h == 0) : (h == m_prev_h + 1);
        v_step    = (m_prev_v == 524) ? (v == 0) : (v == m_prev_v + 1);
        v_ok      = (v == m_prev_v) || (h == 0 && v_step);
        bad       = range_bad || (m_armed && !(h_ok && v_ok));
        m_armed   = 1'b1;
        m_prev_h  = h;
        m_prev_v  = v;
        e.vid = !bad && h < 640 && v < 480;
        e.hs  = !(!bad && h >= 656 && h < 752);
        e.vs  = !(!bad && v >= 490 && v < 492);
        e.px  = e.vid ? 10'(h) : 10'd0;
        e.py  = e.vid ? 10'(v) : 10'd0;
        e.ls  = !bad && h == 0;
        e.fs  = e.ls && v == 0;
        if (e.fs) m_fc = m_fc + 8'd1;
        e.fc  = m_fc;
        m_err = m_err | bad;
        e.err = m_err;
        q.push_back(e);

        h_cnt  = 11'(h);
        v_cnt  = 11'(v);
        pix_en = 1'b1;
        @(posedge Clk);
        #1;
        pix_en = 1'b0;
        if (q.size() == 2) begin
            last_exp = q.pop_front();
            compare_out(last_exp, 1'b0);
        end
        @(posedge Clk);
        #1;
        check_eq("ls_gap", 32'(line_start), 32'd0);
        check_eq("fs_gap", 32'(frame_start), 32'd0);
    endtask

    task automatic hold_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
            compare_out(last_exp, 1'b1);
        end
    endtask

    initial begin
        m_armed = 1'b0;
        m_fc    = '0;
        m_err   = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        do_reset();

        // Lines 488..493: vsync window, hsync window each line, pix_en stall mid-line.
        for (int v = 488; v <= 493; v++) begin
            for (int h = 0; h < 800; h++) begin
                drive(h, v);
                if (v == 490 && h == 1) begin
                    check_eq("ls_before_hold", 32'(line_start), 32'd0);
                    hold_idle(10);
                end
            end
        end
        check_eq("scan_cnt_err", 32'(cnt_err), 32'd0);

        // Right edge of the active area on the last visible line.
        do_reset();
        for (int h = 630; h <= 645; h++) begin
            drive(h, 479);
            if (h == 640) begin
                check_eq("edge_vid_639", 32'(video_on), 32'd1);
                check_eq("edge_px_639", 32'(pixel_x), 32'd639);
                check_eq("edge_py_479", 32'(pixel_y), 32'd479);
            end
            if (h == 641) check_eq("edge_vid_640", 32'(video_on), 32'd0);
        end

        // Frame boundary crossing.
        do_reset();
        for (int h = 790; h < 800; h++) drive(h, 524);
        for (int h = 0; h <= 10; h++) begin
            drive(h, 0);
            if (h == 1) begin
                check_eq("frame_cnt_after_wrap", 32'(frame_cnt), 32'd1);
            end
        end

        // Jump into active video (error), then reset mid-frame at (300,200).
        for (int h = 290; h <= 300; h++) drive(h, 200);
        check_eq("pre_rst_err", 32'(cnt_err), 32'd1);
        do_reset();

        // 256 frame starts via forced jumps to the last pixel: frame_cnt wraps to 0.
        for (int f = 0; f < 256; f++) begin
            drive(799, 524);
            drive(0, 0);
        end
        drive(1, 0);
        check_eq("frame_cnt_wrap", 32'(frame_cnt), 32'd0);

        // Horizontal jump, then out-of-range vertical, then recovery.
        do_reset();
        for (int h = 95; h <= 100; h++) drive(h, 100);
        drive(105, 100);
        drive(106, 100);
        check_eq("jump_err", 32'(cnt_err), 32'd1);
        check_eq("jump_blank", 32'(video_on), 32'd0);
        drive(107, 600);
        drive(108, 100);
        check_eq("range_blank", 32'(video_on), 32'd0);
        for (int h = 109; h <= 112; h++) drive(h, 100);
        check_eq("recover_vid", 32'(video_on), 32'd1);
        check_eq("recover_px", 32'(pixel_x), 32'd111);
        check_eq("sticky_err", 32'(cnt_err), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
